// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: memory rw flags, FSM states, grant sizing.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_RW_IDLE  = 2'b00;
  localparam logic [1:0] MEM_RW_READ  = 2'b01;
  localparam logic [1:0] MEM_RW_WRITE = 2'b10;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // 11 is illegal and must never be granted.
  function automatic logic is_valid_req(input logic [1:0] flag);
    return (flag == MEM_RW_READ) || (flag == MEM_RW_WRITE);
  endfunction

  function automatic int grant_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational grant picker: round-robin after last_grant, or lowest index first when
// MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arb_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int PORT_COUNT = 2,
  localparam int GW = grant_width(PORT_COUNT)
) (
  input  logic [PORT_COUNT-1:0] valid,
  input  logic [GW-1:0]         last_grant,
  output logic [PORT_COUNT-1:0] grant_onehot,
  output logic [GW-1:0]         grant_idx,
  output logic                  found
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (!found && valid[i]) begin
        found           = 1'b1;
        grant_idx       = GW'(i);
        grant_onehot[i] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int cand;
    cand         = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    // Search starts just after the previous winner and wraps, so every port gets a turn.
    for (int off = 1; off <= PORT_COUNT; off++) begin
      cand = (int'(last_grant) + off) % PORT_COUNT;
      if (!found && valid[cand]) begin
        found              = 1'b1;
        grant_idx          = GW'(cand);
        grant_onehot[cand] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter in front of the single-port memory controller, one transaction at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PORT_COUNT = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int MASK_WIDTH = DATA_WIDTH / 8,
  localparam int GW = grant_width(PORT_COUNT)
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  // Upstream handshake: a port raises rw_flag (01/10) with addr/data/mask and holds all of
  // them stable until it sees its one-cycle UP_done; UP_busy tracks that pending window.
  input  logic [PORT_COUNT*2-1:0]          UP_rw_flag,
  input  logic [PORT_COUNT*ADDR_WIDTH-1:0] UP_addr,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] UP_write_data,
  input  logic [PORT_COUNT*MASK_WIDTH-1:0] UP_write_mask,
  output logic [PORT_COUNT*DATA_WIDTH-1:0] UP_read_data,
  output logic [PORT_COUNT-1:0]            UP_busy,
  output logic [PORT_COUNT-1:0]            UP_done,
  output logic [1:0]                       DN_rw_flag,
  output logic [ADDR_WIDTH-1:0]            DN_addr,
  output logic [DATA_WIDTH-1:0]            DN_write_data,
  output logic [MASK_WIDTH-1:0]            DN_write_mask,
  input  logic [DATA_WIDTH-1:0]            DN_read_data,
  input  logic                             DN_busy,
  input  logic                             DN_done,
  output arb_state_e                       dbg_state
);

  arb_state_e                       state_q;
  logic [GW-1:0]                    grant_q;
  logic [GW-1:0]                    last_grant_q;
  logic [PORT_COUNT-1:0]            grant_oh_q;
  logic [1:0]                       cap_flag_q;
  logic [ADDR_WIDTH-1:0]            cap_addr_q;
  logic [DATA_WIDTH-1:0]            cap_data_q;
  logic [MASK_WIDTH-1:0]            cap_mask_q;
  logic [PORT_COUNT-1:0]            done_q;
  logic [PORT_COUNT*DATA_WIDTH-1:0] rdata_q;

  logic [PORT_COUNT-1:0] req_valid;
  logic [PORT_COUNT-1:0] pick_onehot;
  logic [GW-1:0]         pick_idx;
  logic                  pick_found;

  logic unused_dn_busy;
  assign unused_dn_busy = DN_busy;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      req_valid[i] = is_valid_req(UP_rw_flag[2*i +: 2]);
    end
  end

  mem_arb_rr_pick #(
    .PORT_COUNT (PORT_COUNT)
  ) u_pick (
    .valid        (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .found        (pick_found)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(PORT_COUNT - 1);
      grant_oh_q   <= '0;
      cap_flag_q   <= MEM_RW_IDLE;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
      cap_mask_q   <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          // The UP_done cycle is the bubble: the finishing port still shows its old request,
          // so nobody is granted until that port has had a chance to drop it.
          if (pick_found && (done_q == '0)) begin
            grant_q    <= pick_idx;
            grant_oh_q <= pick_onehot;
            cap_flag_q <= UP_rw_flag[2*int'(pick_idx) +: 2];
            cap_addr_q <= UP_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            cap_data_q <= UP_write_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            cap_mask_q <= UP_write_mask[int'(pick_idx)*MASK_WIDTH +: MASK_WIDTH];
            state_q    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (DN_done) begin
            if (cap_flag_q == MEM_RW_READ) begin
              rdata_q[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] <= DN_read_data;
            end
            done_q       <= grant_oh_q;
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign DN_rw_flag    = (state_q == ARB_BUSY) ? cap_flag_q : MEM_RW_IDLE;
  assign DN_addr       = cap_addr_q;
  assign DN_write_data = cap_data_q;
  assign DN_write_mask = cap_mask_q;
  assign UP_done       = done_q;
  assign UP_read_data  = rdata_q;
  // Forced low during reset so every output reads 0 while RST_N is held.
  assign UP_busy       = req_valid & ~done_q & {PORT_COUNT{RST_N}};
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with two ports; the memory side is driven by tasks.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int P  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic              clk;
  logic              rst_n;
  logic [P*2-1:0]    up_rw_flag;
  logic [P*AW-1:0]   up_addr;
  logic [P*DW-1:0]   up_write_data;
  logic [P*MW-1:0]   up_write_mask;
  logic [P*DW-1:0]   up_read_data;
  logic [P-1:0]      up_busy;
  logic [P-1:0]      up_done;
  logic [1:0]        dn_rw_flag;
  logic [AW-1:0]     dn_addr;
  logic [DW-1:0]     dn_write_data;
  logic [MW-1:0]     dn_write_mask;
  logic [DW-1:0]     dn_read_data;
  logic              dn_busy;
  logic              dn_done;
  arb_state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_port_q[$];
  logic [DW-1:0] exp_slice[P];

  mem_port_arbiter #(
    .PORT_COUNT (P),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .UP_rw_flag    (up_rw_flag),
    .UP_addr       (up_addr),
    .UP_write_data (up_write_data),
    .UP_write_mask (up_write_mask),
    .UP_read_data  (up_read_data),
    .UP_busy       (up_busy),
    .UP_done       (up_done),
    .DN_rw_flag    (dn_rw_flag),
    .DN_addr       (dn_addr),
    .DN_write_data (dn_write_data),
    .DN_write_mask (dn_write_mask),
    .DN_read_data  (dn_read_data),
    .DN_busy       (dn_busy),
    .DN_done       (dn_done),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dn_busy = (dn_rw_flag != 2'b00);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [1:0] f, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    up_rw_flag[2*p +: 2]     = f;
    up_addr[p*AW +: AW]      = a;
    up_write_data[p*DW +: DW] = d;
    up_write_mask[p*MW +: MW] = m;
  endtask

  task automatic mem_complete(input logic [DW-1:0] data);
    dn_done      = 1'b1;
    dn_read_data = data;
    tick();
    dn_done      = 1'b0;
    dn_read_data = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < P; i++) exp_slice[i] = '0;
  endtask

  // scenarios
  task automatic test_reset();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({dn_rw_flag, dn_addr, dn_write_data, dn_write_mask} !== '0) begin
      errors++;
      $display("FAIL reset_dn got flag=%h addr=%h data=%h mask=%h exp all 0",
               dn_rw_flag, dn_addr, dn_write_data, dn_write_mask);
    end
    checks++;
    if ({up_read_data, up_busy, up_done} !== '0) begin
      errors++;
      $display("FAIL reset_up got rdata=%h busy=%b done=%b exp all 0", up_read_data, up_busy, up_done);
    end
    checks++;
    if (dbg_state !== ARB_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, ARB_IDLE);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    tick();
    set_port(0, MEM_RW_READ, 32'h100, '0, '0);
    @(negedge clk);
    checks++;
    if (up_busy !== 2'b01) begin
      errors++;
      $display("FAIL read_busy got %b exp %b", up_busy, 2'b01);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dn_rw_flag !== MEM_RW_READ || dn_addr !== 32'h100) begin
      errors++;
      $display("FAIL read_issue got flag=%b addr=%h exp flag=01 addr=00000100", dn_rw_flag, dn_addr);
    end
    tick();
    tick();
    tick();
    exp_q.push_back(32'hDEADBEEF);
    exp_port_q.push_back(0);
    mem_complete(32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (up_done !== 2'b01) begin
      errors++;
      $display("FAIL read_done got %b exp %b", up_done, 2'b01);
    end
    if (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      int            p;
      e = exp_q.pop_front();
      p = exp_port_q.pop_front();
      exp_slice[p] = e;
      checks++;
      if (up_read_data[p*DW +: DW] !== e) begin
        errors++;
        $display("FAIL read_slice0 got %h exp %h", up_read_data[p*DW +: DW], e);
      end
    end
    checks++;
    if (up_read_data[DW +: DW] !== exp_slice[1]) begin
      errors++;
      $display("FAIL read_slice1_kept got %h exp %h", up_read_data[DW +: DW], exp_slice[1]);
    end
    checks++;
    if (dn_rw_flag !== MEM_RW_IDLE) begin
      errors++;
      $display("FAIL read_bubble got %b exp 00", dn_rw_flag);
    end
    tick();
    set_port(0, MEM_RW_IDLE, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (dn_rw_flag !== MEM_RW_IDLE || up_done !== 2'b00) begin
      errors++;
      $display("FAIL read_no_reissue got flag=%b done=%b exp flag=00 done=00", dn_rw_flag, up_done);
    end
  endtask

  task automatic test_back_to_back();
    int exp_port;
    int last;
    do_reset();
    set_port(0, MEM_RW_READ, 32'h10, '0, '0);
    set_port(1, MEM_RW_READ, 32'h20, '0, '0);
    last = P - 1;
    for (int n = 0; n < 4; n++) begin
      logic          found;
      logic [DW-1:0] rd;
      int            lat;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = (last + 1) % P;
`endif
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        @(negedge clk);
        if (dn_rw_flag !== MEM_RW_IDLE) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL b2b_issue_timeout got flag=%b exp 01 within 6 cycles (txn %0d)", dn_rw_flag, n);
        return;
      end
      checks++;
      if (dn_addr !== ((exp_port == 0) ? 32'h10 : 32'h20)) begin
        errors++;
        $display("FAIL b2b_grant_order got addr=%h exp port %0d (txn %0d)", dn_addr, exp_port, n);
      end
      rd  = $urandom;
      lat = $urandom_range(1, 3);
      tick();
      for (int k = 1; k < lat; k++) tick();
      exp_q.push_back(rd);
      exp_port_q.push_back(exp_port);
      mem_complete(rd);
      @(negedge clk);
      checks++;
      if (up_done !== (2'b01 << exp_port) || dn_rw_flag !== MEM_RW_IDLE) begin
        errors++;
        $display("FAIL b2b_done got done=%b flag=%b exp done=%b flag=00 (txn %0d)",
                 up_done, dn_rw_flag, 2'b01 << exp_port, n);
      end
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        int            p;
        e = exp_q.pop_front();
        p = exp_port_q.pop_front();
        exp_slice[p] = e;
        checks++;
        if (up_read_data[p*DW +: DW] !== e) begin
          errors++;
          $display("FAIL b2b_rdata got %h exp %h (txn %0d)", up_read_data[p*DW +: DW], e, n);
        end
      end
      last = exp_port;
    end
    tick();
    set_port(0, MEM_RW_IDLE, '0, '0, '0);
    set_port(1, MEM_RW_IDLE, '0, '0, '0);
  endtask

  task automatic test_write();
    tick();
    set_port(1, MEM_RW_WRITE, 32'h2000, 32'h12345678, 4'b0011);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (dn_rw_flag !== MEM_RW_WRITE || dn_addr !== 32'h2000 ||
          dn_write_data !== 32'h12345678 || dn_write_mask !== 4'b0011) begin
        errors++;
        $display("FAIL write_dn cyc %0d got flag=%b addr=%h data=%h mask=%b exp 10 00002000 12345678 0011",
                 c, dn_rw_flag, dn_addr, dn_write_data, dn_write_mask);
      end
    end
    tick();
    exp_q.push_back(exp_slice[1]);
    exp_port_q.push_back(1);
    mem_complete(32'hBAD0BAD0);
    @(negedge clk);
    checks++;
    if (up_done !== 2'b10) begin
      errors++;
      $display("FAIL write_done got %b exp %b", up_done, 2'b10);
    end
    if (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      int            p;
      e = exp_q.pop_front();
      p = exp_port_q.pop_front();
      checks++;
      if (up_read_data[p*DW +: DW] !== e || up_read_data[0 +: DW] !== exp_slice[0]) begin
        errors++;
        $display("FAIL write_slices_kept got %h exp %h", up_read_data, {e, exp_slice[0]});
      end
    end
    tick();
    set_port(1, MEM_RW_IDLE, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (up_done !== 2'b00) begin
      errors++;
      $display("FAIL write_done_once got %b exp 00", up_done);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic found;
    tick();
    set_port(0, MEM_RW_READ, 32'h300, '0, '0);
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (dn_rw_flag !== MEM_RW_READ) begin
      errors++;
      $display("FAIL rst_pre_issue got %b exp 01", dn_rw_flag);
    end
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < P; i++) exp_slice[i] = '0;
    #1;
    checks++;
    if ({dn_rw_flag, dn_addr, dn_write_data, dn_write_mask, up_read_data, up_busy, up_done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_busy got flag=%b addr=%h rdata=%h busy=%b done=%b exp all 0",
               dn_rw_flag, dn_addr, up_read_data, up_busy, up_done);
    end
    checks++;
    if (dbg_state !== ARB_IDLE) begin
      errors++;
      $display("FAIL rst_mid_state got %0d exp %0d", dbg_state, ARB_IDLE);
    end
    tick();
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 6 && !found; w++) begin
      @(negedge clk);
      if (dn_rw_flag === MEM_RW_READ && dn_addr === 32'h300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_reissue_timeout got flag=%b addr=%h exp 01 00000300", dn_rw_flag, dn_addr);
    end
    tick();
    tick();
    exp_q.push_back(32'hCAFE0001);
    exp_port_q.push_back(0);
    mem_complete(32'hCAFE0001);
    @(negedge clk);
    checks++;
    if (up_done !== 2'b01) begin
      errors++;
      $display("FAIL rst_reissue_done got %b exp 01", up_done);
    end
    if (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      int            p;
      e = exp_q.pop_front();
      p = exp_port_q.pop_front();
      exp_slice[p] = e;
      checks++;
      if (up_read_data[p*DW +: DW] !== e) begin
        errors++;
        $display("FAIL rst_reissue_rdata got %h exp %h", up_read_data[p*DW +: DW], e);
      end
    end
    tick();
    set_port(0, MEM_RW_IDLE, '0, '0, '0);
  endtask

  task automatic test_illegal_flag();
    logic [DW-1:0] rd;
    tick();
    set_port(0, 2'b11, 32'h500, '0, '0);
    set_port(1, MEM_RW_READ, 32'h440, '0, '0);
    @(negedge clk);
    checks++;
    if (up_busy !== 2'b10) begin
      errors++;
      $display("FAIL illegal_busy got %b exp 10", up_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dn_rw_flag !== MEM_RW_READ || dn_addr !== 32'h440) begin
      errors++;
      $display("FAIL illegal_grant got flag=%b addr=%h exp 01 00000440", dn_rw_flag, dn_addr);
    end
    tick();
    rd = $urandom;
    exp_q.push_back(rd);
    exp_port_q.push_back(1);
    mem_complete(rd);
    @(negedge clk);
    checks++;
    if (up_done !== 2'b10) begin
      errors++;
      $display("FAIL illegal_done got %b exp 10", up_done);
    end
    if (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      int            p;
      e = exp_q.pop_front();
      p = exp_port_q.pop_front();
      exp_slice[p] = e;
      checks++;
      if (up_read_data[p*DW +: DW] !== e) begin
        errors++;
        $display("FAIL illegal_rdata got %h exp %h", up_read_data[p*DW +: DW], e);
      end
    end
    tick();
    set_port(1, MEM_RW_IDLE, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (dn_rw_flag !== MEM_RW_IDLE || up_busy !== 2'b00) begin
        errors++;
        $display("FAIL illegal_no_issue cyc %0d got flag=%b busy=%b exp 00 00", c, dn_rw_flag, up_busy);
      end
      tick();
    end
    mem_complete(32'hFFFF0000);
    @(negedge clk);
    checks++;
    if (up_done !== 2'b00 || up_read_data !== {exp_slice[1], exp_slice[0]}) begin
      errors++;
      $display("FAIL idle_dn_done got done=%b rdata=%h exp done=00 rdata=%h",
               up_done, up_read_data, {exp_slice[1], exp_slice[0]});
    end
    tick();
    set_port(0, MEM_RW_IDLE, '0, '0, '0);
  endtask

  // sequence and final report
  initial begin
    rst_n         = 1'b0;
    up_rw_flag    = '0;
    up_addr       = '0;
    up_write_data = '0;
    up_write_mask = '0;
    dn_read_data  = '0;
    dn_done       = 1'b0;
    for (int i = 0; i < P; i++) exp_slice[i] = '0;

    test_reset();
    test_single_read();
    test_back_to_back();
    test_write();
    test_reset_mid_busy();
    test_illegal_flag();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
